// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  localparam int MAX_WAIT_DEF = 8;

endpackage

// File: rtl/fetch_watchdog.sv
// Consecutive-wait counter for the memory request.
// tc is high during the MAX_WAIT-th consecutive waiting cycle.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Clear outside a request, count each unacknowledged request cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one memory read per instruction, registered hand-off to
// decode, single pc_en pulse per delivered instruction, sticky timeout.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_d;
  logic              valid_d, pc_en_d, err_d;
  logic              wd_tc;

  // Counter is held at zero outside REQ, so every REQ entry starts fresh.
  fetch_watchdog #(.MAX_WAIT(MAX_WAIT)) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (state != REQ),
    .inc ((state == REQ) && !imem_ack),
    .tc  (wd_tc)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_en       <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_d;
      addr_q      <= addr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      pc_en       <= pc_en_d;
      fetch_err   <= err_d;
    end
  end

  // Next state and next output values; flush outranks ack, transfer and
  // timeout everywhere except ERR.
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    instr_d = instr;
    valid_d = instr_valid;
    pc_en_d = 1'b0;
    err_d   = fetch_err;
    case (state)
      IDLE: begin
        // On flush the PC is loading the target this cycle; capture next cycle.
        if (!flush) begin
          addr_d  = pc;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = IDLE;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          pc_en_d = 1'b1;
          state_d = HOLD;
        end else if (wd_tc) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      HOLD: begin
        if (flush || instr_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (MAX_WAIT=4): a per-cycle vector
// table plus hand sequences around asynchronous reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        fetch_err;

  int n_chk = 0;
  int n_fail = 0;

  instruction_fetch #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .flush       (flush),
    .pc_en       (pc_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // One record per clock cycle: inputs for the cycle and the outputs
  // expected during it (all outputs depend on registered state only).
  typedef struct {
    logic        fl, ack, rdy;
    logic [31:0] pc, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic        e_pcen, e_err;
  } vec_t;

  function automatic vec_t v(logic fl, logic ack, logic rdy, logic [31:0] p,
                             logic [31:0] rd, logic e_req, logic [31:0] e_addr,
                             logic e_vld, logic [31:0] e_instr, logic e_pcen,
                             logic e_err);
    vec_t r;
    r.fl = fl; r.ack = ack; r.rdy = rdy; r.pc = p; r.rdata = rd;
    r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld;
    r.e_instr = e_instr; r.e_pcen = e_pcen; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t r);
    chk({tag, " imem_req"},    32'(imem_req),    32'(r.e_req));
    chk({tag, " imem_addr"},   imem_addr,        r.e_addr);
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(r.e_vld));
    chk({tag, " instr"},       instr,            r.e_instr);
    chk({tag, " pc_en"},       32'(pc_en),       32'(r.e_pcen));
    chk({tag, " fetch_err"},   32'(fetch_err),   32'(r.e_err));
  endtask

  // Drive one cycle's inputs at the falling edge and check outputs there.
  task automatic step(input string tag, input vec_t r);
    @(negedge clk);
    flush       = r.fl;
    imem_ack    = r.ack;
    instr_ready = r.rdy;
    pc          = r.pc;
    imem_rdata  = r.rdata;
    check_outs(tag, r);
  endtask

  // Leave reset just after a rising edge so the next cycle is IDLE.
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Assert reset between edges and check outputs without any clock edge.
  task automatic mid_cycle_rst(input string tag);
    vec_t z;
    z = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outs(tag, z);
  endtask

  localparam logic [31:0] I0 = 32'h8C220004;
  localparam logic [31:0] I1 = 32'h11111111;
  localparam logic [31:0] I2 = 32'hCAFEF00D;

  vec_t tbl[29];

  initial begin
    // fl ack rdy pc rdata | req addr vld instr pcen err
    tbl[0]  = v(0, 0, 1, 32'h10, 0,  0, 32'h00, 0, 0,  0, 0);  // IDLE after reset
    tbl[1]  = v(0, 0, 1, 32'h10, 0,  1, 32'h10, 0, 0,  0, 0);  // REQ #1
    tbl[2]  = v(0, 0, 1, 32'h10, 0,  1, 32'h10, 0, 0,  0, 0);  // REQ #2
    tbl[3]  = v(0, 1, 1, 32'h10, I0, 1, 32'h10, 0, 0,  0, 0);  // ack
    tbl[4]  = v(0, 0, 1, 32'h10, 0,  0, 32'h10, 1, I0, 1, 0);  // HOLD, transfer
    tbl[5]  = v(0, 0, 1, 32'h14, 0,  0, 32'h10, 0, I0, 0, 0);  // IDLE
    tbl[6]  = v(0, 1, 1, 32'h14, I1, 1, 32'h14, 0, I0, 0, 0);  // REQ, 1-cycle ack
    tbl[7]  = v(0, 0, 0, 32'h14, 0,  0, 32'h14, 1, I1, 1, 0);  // HOLD, stalled
    for (int i = 8; i <= 11; i++)
      tbl[i] = v(0, 0, 0, 32'h18, 0, 0, 32'h14, 1, I1, 0, 0);  // backpressure
    tbl[12] = v(0, 0, 1, 32'h18, 0,  0, 32'h14, 1, I1, 0, 0);  // ready -> transfer
    tbl[13] = v(0, 0, 1, 32'h18, 0,  0, 32'h14, 0, I1, 0, 0);  // IDLE
    tbl[14] = v(1, 1, 1, 32'h18, 32'hDEAD, 1, 32'h18, 0, I1, 0, 0); // flush + ack
    tbl[15] = v(0, 0, 1, 32'h40, 0,  0, 32'h18, 0, I1, 0, 0);  // IDLE, target in pc
    for (int i = 16; i <= 18; i++)
      tbl[i] = v(0, 0, 1, 32'h40, 0, 1, 32'h40, 0, I1, 0, 0);  // waiting
    tbl[19] = v(0, 1, 1, 32'h40, I2, 1, 32'h40, 0, I1, 0, 0);  // ack in 4th REQ
    tbl[20] = v(0, 0, 1, 32'h40, 0,  0, 32'h40, 1, I2, 1, 0);  // delivered
    tbl[21] = v(0, 0, 1, 32'h44, 0,  0, 32'h40, 0, I2, 0, 0);  // IDLE
    for (int i = 22; i <= 25; i++)
      tbl[i] = v(0, 0, 1, 32'h44, 0, 1, 32'h44, 0, I2, 0, 0);  // never acked
    tbl[26] = v(1, 0, 1, 32'h44, 0,  0, 32'h44, 0, I2, 0, 1);  // ERR, flush
    tbl[27] = v(1, 1, 1, 32'h48, 0,  0, 32'h44, 0, I2, 0, 1);  // ERR, flush ignored
    tbl[28] = v(0, 0, 1, 32'h48, 0,  0, 32'h44, 0, I2, 0, 1);  // still ERR

    // Reset state while rst is held.
    @(negedge clk);
    check_outs("reset", v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    release_rst();

    for (int i = 0; i < 29; i++)
      step($sformatf("row%0d", i), tbl[i]);

    // Asynchronous reset clears the sticky error.
    mid_cycle_rst("err_clear");
    release_rst();

    // Fetch, then reset mid-cycle while the instruction is held.
    step("b0", v(0, 0, 1, 32'h80, 0,  0, 32'h00, 0, 0,  0, 0));
    step("b1", v(0, 1, 1, 32'h80, 32'h55, 1, 32'h80, 0, 0, 0, 0));
    step("b2", v(0, 0, 0, 32'h84, 0,  0, 32'h80, 1, 32'h55, 1, 0));
    mid_cycle_rst("rst_in_hold");
    release_rst();

    // Reset in the middle of an outstanding request.
    step("c0", v(0, 0, 1, 32'h90, 0,  0, 32'h00, 0, 0,  0, 0));
    step("c1", v(0, 0, 1, 32'h90, 0,  1, 32'h90, 0, 0,  0, 0));
    mid_cycle_rst("rst_in_req");
    release_rst();

    // Restart from IDLE after the reset.
    step("d0", v(0, 0, 1, 32'hA0, 0,  0, 32'h00, 0, 0,  0, 0));
    step("d1", v(0, 1, 1, 32'hA0, 32'h77, 1, 32'hA0, 0, 0, 0, 0));
    step("d2", v(0, 0, 1, 32'hA0, 0,  0, 32'hA0, 1, 32'h77, 1, 0));
    step("d3", v(0, 0, 1, 32'hA4, 0,  0, 32'hA0, 0, 32'h77, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly downstream of `program_counter`. It takes the current `pc` and issues a request/acknowledge read to instruction memory. It registers the returned word for the decode stage under a valid/ready handshake, and pulses `pc_en` so the PC stage advances exactly once per fetched instruction. A watchdog flags a memory that never acknowledges. A flush input discards in-flight work on a taken branch or jump.

## Interface
- `ADDR_W`, 32, width of `pc` and `imem_addr`
- `DATA_W`, 32, instruction width
- `MAX_WAIT`, 8, maximum consecutive REQ cycles without `imem_ack` before error (≥1)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  ADDR_W  current program counter from `program_counter`
- `flush`  in  1  redirect pulse, coincident with the PC loading a branch/jump target
- `pc_en`  out  1  one-cycle pulse; PC stage advances on it
- `imem_req`  out  1  memory read request
- `imem_addr`  out  ADDR_W  read address, stable while `imem_req`=1
- `imem_ack`  in  1  read done; `imem_rdata` valid this cycle; meaningful only while `imem_req`=1
- `imem_rdata`  in  DATA_W  read data
- `instr`  out  DATA_W  fetched instruction
- `instr_valid`  out  1  `instr` holds an untaken instruction
- `instr_ready`  in  1  decode accepts; transfer when `instr_valid` & `instr_ready`
- `fetch_err`  out  1  sticky watchdog error

## Operation
- States:
  - **IDLE**: one cycle. Captures `pc` into `addr_q` at exit. Goes to REQ.
  - **REQ**: `imem_req`=1, `imem_addr`=`addr_q`.
    - On `imem_ack`: `instr`<=`imem_rdata`, `instr_valid`<=1, `pc_en`<=1, go to HOLD.
  - **HOLD**: `instr_valid`=1 and `instr` stable. On transfer, `instr_valid`<=0 and go to IDLE.
  - **ERR**: terminal. `imem_req`, `instr_valid` and `pc_en` all 0. Exit only via `rst`.
- Reset values:
  - State IDLE.
  - `addr_q`/`imem_addr`=0, `instr`=0.
  - `instr_valid`=0, `pc_en`=0, `imem_req`=0, `fetch_err`=0.
- `imem_req` is decoded from state. All other outputs are registered.
- `pc_en` is high for exactly one cycle per acknowledged, non-flushed fetch.
- Watchdog:
  - Counter (width clog2(`MAX_WAIT`+1)) is cleared on REQ entry and increments each REQ cycle without ack.
  - If the `MAX_WAIT`-th consecutive REQ cycle has no ack, at that edge: `fetch_err`<=1 and state<=ERR.
  - An ack in the `MAX_WAIT`-th cycle is accepted normally.
- Flush (any state except ERR) has priority over `imem_ack` and transfer:
  - Next state IDLE, `instr_valid`<=0, no `pc_en` pulse.
  - Abandoned request: `imem_req` drops the next cycle, and memory treats the read as cancelled.
- Flush in ERR is ignored.
- `rst` asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

## Timing
- Ack in cycle n gives:
  - `instr_valid` and `pc_en` high in n+1.
  - PC updates at the end of n+1.
- Earliest transfer is in n+1. IDLE in n+2 captures the updated `pc` at the end of n+2, and REQ starts in n+3.
- Peak throughput: one instruction per 3 cycles with 1-cycle memory.
- First request after reset: REQ in the 2nd cycle after `rst` deasserts, address = `pc` sampled at the end of the first cycle.
- Flush in cycle n: IDLE in n+1 (PC holds the target), target address captured at the end of n+1.
- Backpressure (`instr_ready`=0) holds HOLD indefinitely. No new request and no further `pc_en` are issued.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, REQ, HOLD, ERR) and the default `MAX_WAIT` constant.
- One sub-module, `fetch_watchdog`: clear/increment counter with a terminal-count flag, parameterised by `MAX_WAIT`.
- Everything else is flat in `instruction_fetch`.

## Test plan
- **Reset, basic fetch**: `pc`=0x10, ack 2 cycles after `imem_req`, rdata=0x8C220004.
  - `imem_addr`=0x10.
  - `instr`=0x8C220004 and `instr_valid`=1 the cycle after ack.
  - `pc_en` high exactly one cycle.
- **Backpressure**: `instr_ready`=0 for 5 cycles after valid.
  - `instr` stable, `instr_valid` held, `imem_req`=0, single `pc_en`.
  - Raising ready leads to IDLE, then REQ at the new `pc`.
- **Flush coincident with ack**: `pc` loaded to 0x40 the same cycle.
  - No `instr_valid`, no `pc_en`.
  - Next request has `imem_addr`=0x40 two cycles later.
- **Timeout**: `MAX_WAIT`=4, ack never asserted.
  - `fetch_err`=1 after the 4th REQ cycle, then `imem_req`=0.
  - Flush ignored in ERR; `rst` clears `fetch_err`.
- **Ack on the boundary**: `MAX_WAIT`=4, ack in the 4th REQ cycle.
  - Instruction delivered, `fetch_err` stays 0.
- **Async reset mid-REQ**: `rst` pulsed between clock edges.
  - `imem_req` and `instr_valid` drop immediately, all outputs take reset values.
  - Fetch restarts from IDLE.
